// File: rtl/pi_bus_pkg.sv
// rtl/pi_bus_pkg.sv - shared constants, types and helpers for the picoblaze bus hub
package pi_bus_pkg;

  // Hub-local register offsets (port_id[3:0] when port_id[7:4] == HUB_BLK)
  localparam logic [3:0] HUB_STATUS_L = 4'h0;
  localparam logic [3:0] HUB_STATUS_H = 4'h1;
  localparam logic [3:0] HUB_MASK_L   = 4'h2;
  localparam logic [3:0] HUB_MASK_H   = 4'h3;
  localparam logic [3:0] HUB_SOURCE   = 4'h4;
  localparam logic [3:0] HUB_EOI      = 4'h5;
  localparam logic [3:0] HUB_IDREG    = 4'h6;

  localparam logic [3:0] DEF_HUB_BLK = 4'hF;
  localparam logic [7:0] DEF_HUB_ID  = 8'hA5;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} irq_state_t;

  // Index of the lowest set bit; 0 when nothing is set
  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pi_bus_hub_if.sv
// rtl/pi_bus_hub_if.sv - picoblaze port bus bundle between the processor and the hub
interface pi_bus_hub_if;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;

  // picoblaze side
  modport master (
    output port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    input  in_port, interrupt
  );

  // hub side
  modport slave (
    input  port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    output in_port, interrupt
  );
endinterface

// File: rtl/pi_irq_ctrl.sv
// rtl/pi_irq_ctrl.sv - per-block irq edge detect, pending/mask, priority source and ack/EOI FSM
module pi_irq_ctrl
  import pi_bus_pkg::*;
#(
  parameter int NUM_BLK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         reg_addr,
  input  logic               reg_wr,
  input  logic [7:0]         reg_wdata,
  input  logic [NUM_BLK-1:0] blk_irq,
  input  logic               interrupt_ack,
  output logic [15:0]        pending16,
  output logic [15:0]        mask16,
  output logic [7:0]         source,
  output logic               interrupt
);

  logic [NUM_BLK-1:0] irq_q;
  logic [NUM_BLK-1:0] pending;
  logic [NUM_BLK-1:0] mask;
  logic [NUM_BLK-1:0] act;
  logic [15:0]        clr16;
  logic               eoi_wr;
  logic               ack_take;
  logic               src_valid;
  logic [3:0]         src_idx;
  irq_state_t         state, state_nxt;

  assign act       = pending & mask;
  assign pending16 = 16'(pending);
  assign mask16    = 16'(mask);
  assign source    = {src_valid, 3'b000, src_idx};
  assign eoi_wr    = reg_wr && (reg_addr == HUB_EOI);

  // Write-1-to-clear vector, spread over the two status bytes
  always_comb begin
    clr16 = '0;
    if (reg_wr) begin
      if (reg_addr == HUB_STATUS_L) clr16[7:0]  = reg_wdata;
      if (reg_addr == HUB_STATUS_H) clr16[15:8] = reg_wdata;
    end
  end

  // Rising-edge detect; a new edge beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q   <= '0;
      pending <= '0;
    end else begin
      irq_q   <= blk_irq;
      pending <= (pending & ~NUM_BLK'(clr16)) | (blk_irq & ~irq_q);
    end
  end

  // Mask register bytes; bits beyond NUM_BLK are dropped by the cast
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
    end else if (reg_wr && reg_addr == HUB_MASK_L) begin
      mask <= NUM_BLK'({mask16[15:8], reg_wdata});
    end else if (reg_wr && reg_addr == HUB_MASK_H) begin
      mask <= NUM_BLK'({reg_wdata, mask16[7:0]});
    end
  end

  // Next state: request on any enabled pending, service after ack, idle after EOI
  always_comb begin
    state_nxt = state;
    ack_take  = 1'b0;
    case (state)
      IDLE:    if (|act) state_nxt = REQ;
      REQ:     if (interrupt_ack) begin
                 state_nxt = SERVICE;
                 ack_take  = 1'b1;
               end
      SERVICE: if (eoi_wr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, registered interrupt and captured source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      interrupt <= 1'b0;
      src_valid <= 1'b0;
      src_idx   <= '0;
    end else begin
      state     <= state_nxt;
      interrupt <= (state == REQ);
      if (ack_take) begin
        src_valid <= |act;
        src_idx   <= lowest_idx(16'(act));
      end else if (state == SERVICE && eoi_wr) begin
        src_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pi_bus_hub.sv
// rtl/pi_bus_hub.sv - picoblaze port_id decoder, read-data OR mux and hub register block
module pi_bus_hub
  import pi_bus_pkg::*;
#(
  parameter int         NUM_BLK = 4,
  parameter logic [3:0] HUB_BLK = DEF_HUB_BLK,
  parameter logic [7:0] HUB_ID  = DEF_HUB_ID
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pi_bus_hub_if.slave          pb,
  output logic [NUM_BLK-1:0]   pi_blk_sel,
  output logic [3:0]           pi_addr,
  output logic                 pi_wr_en,
  output logic                 pi_rd_en,
  output logic [7:0]           pi_wr_data,
  input  logic [8*NUM_BLK-1:0] pi_rd_data,
  input  logic [NUM_BLK-1:0]   blk_irq
);

  logic        hub_sel;
  logic [7:0]  hub_rd_data;
  logic [15:0] pending16;
  logic [15:0] mask16;
  logic [7:0]  source;

  assign hub_sel    = (pb.port_id[7:4] == HUB_BLK);
  assign pi_addr    = pb.port_id[3:0];
  assign pi_wr_en   = pb.write_strobe;
  assign pi_rd_en   = pb.read_strobe;
  assign pi_wr_data = pb.out_port;

  // One-hot block select; hub and unmapped addresses select nothing
  always_comb begin
    pi_blk_sel = '0;
    for (int i = 0; i < NUM_BLK; i++) begin
      if (pb.port_id[7:4] == 4'(i) && !hub_sel) pi_blk_sel[i] = 1'b1;
    end
  end

  // Hub register read mux
  always_comb begin
    hub_rd_data = '0;
    case (pb.port_id[3:0])
      HUB_STATUS_L: hub_rd_data = pending16[7:0];
      HUB_STATUS_H: hub_rd_data = pending16[15:8];
      HUB_MASK_L:   hub_rd_data = mask16[7:0];
      HUB_MASK_H:   hub_rd_data = mask16[15:8];
      HUB_SOURCE:   hub_rd_data = source;
      HUB_IDREG:    hub_rd_data = HUB_ID;
      default:      hub_rd_data = '0;
    endcase
  end

  // OR the selected block's data with the hub value onto in_port
  always_comb begin
    pb.in_port = hub_sel ? hub_rd_data : 8'h00;
    for (int i = 0; i < NUM_BLK; i++) begin
      pb.in_port = pb.in_port | (pi_rd_data[8*i +: 8] & {8{pi_blk_sel[i]}});
    end
  end

  pi_irq_ctrl #(
    .NUM_BLK (NUM_BLK)
  ) u_irq_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .reg_addr      (pb.port_id[3:0]),
    .reg_wr        (hub_sel && pb.write_strobe),
    .reg_wdata     (pb.out_port),
    .blk_irq       (blk_irq),
    .interrupt_ack (pb.interrupt_ack),
    .pending16     (pending16),
    .mask16        (mask16),
    .source        (source),
    .interrupt     (pb.interrupt)
  );

endmodule

// File: tb/tb_pi_bus_hub.sv
// tb/tb_pi_bus_hub.sv - directed self-checking bench for pi_bus_hub
module tb_pi_bus_hub;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] pi_blk_sel;
  logic [3:0]    pi_addr;
  logic          pi_wr_en;
  logic          pi_rd_en;
  logic [7:0]    pi_wr_data;
  logic [8*NB-1:0] pi_rd_data;
  logic [NB-1:0] blk_irq = '0;

  int tests = 0;
  int fails = 0;

  pi_bus_hub_if pb();

  pi_bus_hub #(.NUM_BLK(NB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pb         (pb),
    .pi_blk_sel (pi_blk_sel),
    .pi_addr    (pi_addr),
    .pi_wr_en   (pi_wr_en),
    .pi_rd_en   (pi_rd_en),
    .pi_wr_data (pi_wr_data),
    .pi_rd_data (pi_rd_data),
    .blk_irq    (blk_irq)
  );

  always #5 clk = ~clk;

  // Peripheral blocks: block i returns 8'h10+i when selected, 0 otherwise
  always_comb begin
    pi_rd_data = '0;
    for (int i = 0; i < NB; i++) begin
      if (pi_blk_sel[i]) pi_rd_data[8*i +: 8] = 8'(8'h10 + i);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    pb.port_id = addr;
    pb.out_port = data;
    pb.write_strobe = 1'b1;
    @(posedge clk);
    #1;
    pb.write_strobe = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
    pb.port_id = addr;
    pb.read_strobe = 1'b1;
    #2;
    data = pb.in_port;
    @(posedge clk);
    #1;
    pb.read_strobe = 1'b0;
  endtask

  task automatic pulse_ack();
    pb.interrupt_ack = 1'b1;
    @(posedge clk);
    #1;
    pb.interrupt_ack = 1'b0;
  endtask

  task automatic wait_int(input int n, output logic seen);
    seen = 1'b0;
    for (int k = 0; k < n && !seen; k++) begin
      @(posedge clk);
      #1;
      if (pb.interrupt) seen = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic       seen;
    logic [7:0] exp_d;
    logic [3:0] exp_s;
    logic [3:0] hi;

    pb.port_id = 8'h00;
    pb.out_port = 8'h00;
    pb.write_strobe = 1'b0;
    pb.read_strobe = 1'b0;
    pb.interrupt_ack = 1'b0;

    tick(3);
    check("reset_interrupt", pb.interrupt, 1'b0);
    rst_n = 1'b1;
    tick(2);
    check("idle_interrupt", pb.interrupt, 1'b0);

    // Decode sweep after reset: hub regs are all 0 except ID
    pb.read_strobe = 1'b1;
    for (int p = 0; p < 256; p++) begin
      pb.port_id = 8'(p);
      #1;
      hi = 4'(p >> 4);
      if (hi < 4)            exp_d = 8'(8'h10 + hi);
      else if (p == 8'hF6)   exp_d = 8'hA5;
      else                   exp_d = 8'h00;
      exp_s = (hi < 4) ? 4'(1 << hi) : 4'h0;
      check($sformatf("in_port_%02h", p), pb.in_port, exp_d);
      check($sformatf("blk_sel_%02h", p), pi_blk_sel, exp_s);
    end
    pb.read_strobe = 1'b0;

    // Pass-through
    pb.port_id = 8'h2C;
    pb.out_port = 8'h5A;
    pb.write_strobe = 1'b1;
    #1;
    check("pass_addr", pi_addr, 4'hC);
    check("pass_wdata", pi_wr_data, 8'h5A);
    check("pass_wr", pi_wr_en, 1'b1);
    check("pass_rd", pi_rd_en, 1'b0);
    pb.write_strobe = 1'b0;
    tick(1);

    // Single IRQ: 3 clk latency, held until ack
    bus_write(8'hF2, 8'h08);
    bus_read(8'hF2, rd);
    check("mask_l_rd", rd, 8'h08);
    blk_irq[3] = 1'b1;
    tick(1);
    check("lat_1", pb.interrupt, 1'b0);
    tick(1);
    check("lat_2", pb.interrupt, 1'b0);
    tick(1);
    check("lat_3", pb.interrupt, 1'b1);
    tick(4);
    check("held", pb.interrupt, 1'b1);
    pulse_ack();
    tick(1);
    check("drop_after_ack", pb.interrupt, 1'b0);
    bus_read(8'hF4, rd);
    check("source_83", rd, 8'h83);
    bus_write(8'hF0, 8'h08);
    bus_write(8'hF5, 8'h00);
    bus_read(8'hF0, rd);
    check("status_cleared", rd, 8'h00);
    tick(5);
    check("no_rerequest", pb.interrupt, 1'b0);
    blk_irq[3] = 1'b0;

    // Priority: blocks 1 and 2 together
    bus_write(8'hF2, 8'h0F);
    blk_irq[2:1] = 2'b11;
    wait_int(8, seen);
    check("prio_req", seen, 1'b1);
    pulse_ack();
    bus_read(8'hF4, rd);
    check("source_81", rd, 8'h81);
    bus_write(8'hF0, 8'h02);
    bus_write(8'hF5, 8'h00);
    check("after_eoi_low", pb.interrupt, 1'b0);
    wait_int(4, seen);
    check("prio_rereq", seen, 1'b1);
    pulse_ack();
    bus_read(8'hF4, rd);
    check("source_82", rd, 8'h82);
    bus_write(8'hF0, 8'h04);
    bus_write(8'hF5, 8'h00);
    tick(5);
    check("prio_done", pb.interrupt, 1'b0);
    blk_irq[2:1] = 2'b00;

    // Collision: edge and W1C on bit0 in the same cycle, set wins
    bus_write(8'hF2, 8'h00);
    blk_irq[0] = 1'b1;
    bus_write(8'hF0, 8'h01);
    bus_read(8'hF0, rd);
    check("collision_set_wins", rd, 8'h01);
    bus_write(8'hF0, 8'h01);
    bus_read(8'hF0, rd);
    check("level_cleared", rd, 8'h00);
    tick(100);
    bus_read(8'hF0, rd);
    check("level_no_repend", rd, 8'h00);
    blk_irq[0] = 1'b0;

    // Masked pending never requests
    blk_irq[1] = 1'b1;
    tick(6);
    check("masked_no_int", pb.interrupt, 1'b0);
    bus_read(8'hF0, rd);
    check("masked_pending", rd, 8'h02);

    // Clear during REQ: interrupt held, source captured invalid
    bus_write(8'hF2, 8'h02);
    wait_int(6, seen);
    check("spur_req", seen, 1'b1);
    bus_write(8'hF0, 8'h02);
    tick(3);
    check("spur_held", pb.interrupt, 1'b1);
    pulse_ack();
    tick(1);
    check("spur_drop", pb.interrupt, 1'b0);
    bus_read(8'hF4, rd);
    check("spur_source", rd, 8'h00);
    bus_write(8'hF5, 8'h00);

    // EOI in IDLE is ignored
    bus_write(8'hF5, 8'h00);
    tick(3);
    check("eoi_idle_int", pb.interrupt, 1'b0);
    bus_read(8'hF4, rd);
    check("eoi_idle_source", rd, 8'h00);
    blk_irq[1] = 1'b0;
    tick(2);

    // Async reset mid-REQ
    blk_irq[1] = 1'b1;
    wait_int(8, seen);
    check("rst_req", seen, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_drop", pb.interrupt, 1'b0);
    blk_irq = '0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    bus_read(8'hF0, rd);
    check("rst_status", rd, 8'h00);
    bus_read(8'hF2, rd);
    check("rst_mask", rd, 8'h00);
    bus_read(8'hF4, rd);
    check("rst_source", rd, 8'h00);
    bus_read(8'hF6, rd);
    check("id", rd, 8'hA5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
